// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: frames LSB/MSB-first bit streams into WIDTH-bit
// words and presents them on a one-entry valid/ready buffer with sticky error flags.
module serial_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_start,
  input  logic             msb_first,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             ovr_q, ovr_d;
  logic             ferr_q, ferr_d;

  logic             start, accept, complete, dir_eff;
  logic [WIDTH-1:0] base, word;
  logic [CW-1:0]    cnt_inc;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; a restart inside RECV simply stays in RECV
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = RECV;
      RECV:    if (complete) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == RECV);
  end

  // A start bit always begins from an empty register with the freshly sampled direction
  always_comb begin
    start    = sin_valid & frame_start;
    accept   = sin_valid & (start | (state_q == RECV));
    dir_eff  = start ? msb_first : dir_q;
    base     = start ? '0 : sr_q;
    word     = dir_eff ? {base[WIDTH-2:0], sin} : {sin, base[WIDTH-1:1]};
    cnt_inc  = start ? CW'(1) : cnt_q + CW'(1);
    complete = accept & (cnt_inc == CW'(WIDTH));
  end

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    dout_d = dout_q;
    dv_d   = dv_q;
    ovr_d  = ovr_q & ~clr_err;
    ferr_d = ferr_q & ~clr_err;
    if (accept) begin
      sr_d  = word;
      cnt_d = complete ? '0 : cnt_inc;
      dir_d = dir_eff;
    end
    if (start && state_q == RECV) ferr_d = 1'b1;
    // A completed word lands only if the buffer is empty or drained on this edge
    if (complete) begin
      if (!dv_q || dout_ready) begin
        dout_d = word;
        dv_d   = 1'b1;
      end else begin
        ovr_d  = 1'b1;
      end
    end else if (dv_q && dout_ready) begin
      dv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      dout_q <= dout_d;
      dv_q   <= dv_d;
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign overrun    = ovr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: directed scenarios plus random traffic against
// a bit-queue reference model of framing, buffering and error flags.
module tb_serial_deserializer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         sin, sin_valid, frame_start, msb_first, clr_err, dout_ready;
  logic [W-1:0] dout;
  logic         dout_valid, busy, overrun, frame_err;

  int passed = 0;
  int total  = 0;

  // Reference model state
  logic [W-1:0] m_dout;
  bit           m_valid, m_ovr, m_ferr, m_busy, m_dir;
  int           m_bits[$];

  serial_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
    .frame_start(frame_start), .msb_first(msb_first), .clr_err(clr_err),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_dout = '0; m_valid = 0; m_ovr = 0; m_ferr = 0; m_busy = 0; m_dir = 0;
    m_bits = {};
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, settle 1 time unit
  task automatic step(input bit sv, input bit fs, input bit sb, input bit msb,
                      input bit rdy, input bit clr);
    bit done, oset, fset;
    logic [W-1:0] w;
    sin_valid = sv; frame_start = fs; sin = sb; msb_first = msb;
    dout_ready = rdy; clr_err = clr;
    @(posedge clk);
    done = 0; oset = 0; fset = 0; w = '0;
    if (sv && fs) begin
      if (m_busy) fset = 1;
      m_bits = {};
      m_bits.push_back(int'(sb));
      m_dir  = msb;
      m_busy = 1;
    end else if (sv && m_busy) begin
      m_bits.push_back(int'(sb));
    end
    if (m_busy && m_bits.size() == W) begin
      for (int i = 0; i < W; i++)
        if (m_bits[i] != 0) w[m_dir ? (W-1-i) : i] = 1'b1;
      done = 1; m_bits = {}; m_busy = 0;
    end
    if (done) begin
      if (!m_valid || rdy) begin m_dout = w; m_valid = 1; end
      else oset = 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (clr) begin m_ovr = 0; m_ferr = 0; end
    if (oset) m_ovr = 1;
    if (fset) m_ferr = 1;
    #1;
  endtask

  task automatic idle_inputs();
    sin = 0; sin_valid = 0; frame_start = 0; msb_first = 0; clr_err = 0; dout_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    model_reset();
    #2;
    total++;
    if ({dout, dout_valid, busy, overrun, frame_err} !== '0)
      $display("FAIL reset_outputs got dout=%h v=%b busy=%b ovr=%b ferr=%b want all 0",
               dout, dout_valid, busy, overrun, frame_err);
    else passed++;
    @(negedge clk); rst = 1'b1;
    step(1, 0, 1, 0, 0, 0);  // stray bit without frame_start is ignored
    total++;
    if (busy !== 1'b0 || dout_valid !== 1'b0)
      $display("FAIL reset_ignore_nostart got busy=%b v=%b want 0 0", busy, dout_valid);
    else passed++;
  endtask

  task automatic test_lsb_first();
    step(1, 1, 1, 0, 0, 0);
    total++;
    if (busy !== 1'b1) $display("FAIL lsb_busy got %b want 1", busy); else passed++;
    step(1, 0, 0, 1, 0, 0);  // msb_first flip mid-frame must be ignored
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    total++;
    if (dout !== 4'hD || dout !== m_dout || dout_valid !== 1'b1 || busy !== 1'b0)
      $display("FAIL lsb_word got dout=%h v=%b busy=%b want d 1 0", dout, dout_valid, busy);
    else passed++;
    step(0, 0, 0, 0, 1, 0);
    total++;
    if (dout_valid !== 1'b0) $display("FAIL lsb_consume got v=%b want 0", dout_valid); else passed++;
  endtask

  task automatic test_msb_gaps();
    bit bits[4] = '{1, 0, 1, 1};
    for (int i = 0; i < 4; i++) begin
      step(1, i == 0, bits[i], 1, 0, 0);
      if (i < 3) begin
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
      end
    end
    total++;
    if (dout !== 4'hB || dout !== m_dout || dout_valid !== 1'b1)
      $display("FAIL msb_word got dout=%h v=%b want b 1", dout, dout_valid);
    else passed++;
    step(0, 0, 0, 0, 1, 0);
  endtask

  task automatic send_lsb(input logic [W-1:0] val, input bit rdy_last);
    for (int i = 0; i < W; i++) step(1, i == 0, val[i], 0, (i == W-1) ? rdy_last : 1'b0, 0);
  endtask

  task automatic test_overrun();
    send_lsb(4'hD, 0);
    send_lsb(4'h3, 0);
    total++;
    if (dout !== 4'hD || dout_valid !== 1'b1 || overrun !== 1'b1 || overrun !== m_ovr)
      $display("FAIL overrun_set got dout=%h v=%b ovr=%b want d 1 1", dout, dout_valid, overrun);
    else passed++;
    step(0, 0, 0, 0, 0, 1);
    total++;
    if (overrun !== 1'b0 || dout !== 4'hD)
      $display("FAIL overrun_clr got ovr=%b dout=%h want 0 d", overrun, dout);
    else passed++;
  endtask

  task automatic test_replace_on_ready();
    send_lsb(4'h3, 1);
    total++;
    if (dout !== 4'h3 || dout_valid !== 1'b1 || overrun !== 1'b0)
      $display("FAIL replace_word got dout=%h v=%b ovr=%b want 3 1 0", dout, dout_valid, overrun);
    else passed++;
    step(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_restart();
    step(1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    send_lsb(4'h6, 0);
    total++;
    if (frame_err !== 1'b1 || dout !== 4'h6 || dout !== m_dout)
      $display("FAIL restart_word got ferr=%b dout=%h want 1 6", frame_err, dout);
    else passed++;
    // Set and clear on the same edge: set wins
    step(1, 1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1);
    total++;
    if (frame_err !== 1'b1) $display("FAIL restart_set_wins got ferr=%b want 1", frame_err); else passed++;
    step(0, 0, 0, 0, 0, 1);
    total++;
    if (frame_err !== 1'b0) $display("FAIL restart_clr got ferr=%b want 0", frame_err); else passed++;
  endtask

  task automatic test_midframe_reset();
    send_lsb(4'h9, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    rst = 1'b0;
    model_reset();
    #1;
    total++;
    if ({dout, dout_valid, busy, overrun, frame_err} !== '0)
      $display("FAIL midreset_outputs got dout=%h v=%b busy=%b want all 0", dout, dout_valid, busy);
    else passed++;
    rst = 1'b1;
    send_lsb(4'h3, 0);
    total++;
    if (dout !== 4'h3 || dout_valid !== 1'b1 || frame_err !== 1'b0)
      $display("FAIL midreset_next got dout=%h v=%b ferr=%b want 3 1 0", dout, dout_valid, frame_err);
    else passed++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, 1'($urandom),
           1'($urandom), 1'($urandom), $urandom_range(0, 9) == 0);
      total++;
      if (dout !== m_dout || dout_valid !== m_valid || busy !== m_busy ||
          overrun !== m_ovr || frame_err !== m_ferr) begin
        if (errs < 10)
          $display("FAIL random_cycle%0d got dout=%h v=%b b=%b o=%b f=%b want %h %b %b %b %b",
                   c, dout, dout_valid, busy, overrun, frame_err,
                   m_dout, m_valid, m_busy, m_ovr, m_ferr);
        errs++;
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_gaps();
    test_overrun();
    test_replace_on_ready();
    test_restart();
    test_midframe_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
